usbfs_in_endp: RTL and testbench

USBFS_IN_ENDP -- requirements
Module: usbfs_in_endp

---
 rtl/usbSpec.sv | 36 +++
 rtl/usbfs_pkt_buf.sv | 52 +++++
 rtl/usbfs_in_endp.sv | 144 ++++++++++++++
 tb/tb_usbfs_in_endp.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usbSpec.sv
// Shared USB full-speed definitions: PID codes, PID groups and the IN endpoint state encoding.
package usbSpec;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_DATA2 = 4'b0111;
  localparam logic [3:0] PID_MDATA = 4'b1111;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_NYET  = 4'b0110;

  // The low two PID bits identify the packet class.
  localparam logic [1:0] PIDGROUP_SPECIAL   = 2'b00;
  localparam logic [1:0] PIDGROUP_TOKEN     = 2'b01;
  localparam logic [1:0] PIDGROUP_HANDSHAKE = 2'b10;
  localparam logic [1:0] PIDGROUP_DATA      = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DATA_REQ = 3'd1,
    ST_DATA_TX  = 3'd2,
    ST_ACK_WAIT = 3'd3,
    ST_HS_REQ   = 3'd4,
    ST_HS_TX    = 3'd5
  } in_state_e;

  function automatic logic [3:0] data_pid(input logic toggle);
    return toggle ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/usbfs_pkt_buf.sv
// Packet assembly buffer for the IN endpoint: collects streamed bytes until full or last.
module usbfs_pkt_buf
  import usbSpec::*;
#(
  parameter int MAX_PKT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               byte_data,
  input  logic                     byte_valid,
  input  logic                     byte_last,
  output logic                     byte_ready,
  input  logic                     free,
  output logic [8*MAX_PKT-1:0]     data,
  output logic [$clog2(MAX_PKT):0] count,
  output logic                     complete
);

  localparam int CNT_W = $clog2(MAX_PKT) + 1;

  logic zlp_pending;
  logic accept;
  logic fills;

  assign byte_ready = !complete;
  assign accept     = byte_valid && !complete;
  assign fills      = (count == CNT_W'(MAX_PKT - 1));

  // A last byte that exactly fills the buffer owes the host a trailing zero-length packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      complete    <= 1'b0;
      zlp_pending <= 1'b0;
    end else if (free) begin
      count       <= '0;
      complete    <= zlp_pending;
      zlp_pending <= 1'b0;
    end else if (accept) begin
      count <= count + CNT_W'(1);
      if (fills || byte_last) complete    <= 1'b1;
      if (fills && byte_last) zlp_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_PKT; i++) begin
      if (accept && (count == CNT_W'(i))) data[8*i +: 8] <= byte_data;
    end
  end

endmodule

// File: rtl/usbfs_in_endp.sv
// USB full-speed IN endpoint: answers IN tokens with DATA0/1, NAK or STALL and tracks the data toggle.
module usbfs_in_endp
  import usbSpec::*;
#(
  parameter int MAX_PKT     = 8,
  parameter int ACK_TIMEOUT = 24
) (
  input  logic                     i_clk_12MHz,
  input  logic                     i_rst_n,
  input  logic [7:0]               i_byte,
  input  logic                     i_byte_valid,
  input  logic                     i_byte_last,
  output logic                     o_byte_ready,
  input  logic                     i_inToken,
  input  logic                     i_ackRcvd,
  input  logic                     i_stall,
  input  logic                     i_clrToggle,
  output logic                     o_valid,
  input  logic                     i_ready,
  input  logic                     i_eopDone,
  output logic [3:0]               o_pid,
  output logic [8*MAX_PKT-1:0]     o_data,
  output logic [$clog2(MAX_PKT):0] o_data_nBytes
);

  localparam int CNT_W = $clog2(MAX_PKT) + 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  in_state_e                state;
  logic                     toggle;
  logic [TMR_W-1:0]         timer;
  logic [8*MAX_PKT-1:0]     pkt_data;
  logic [CNT_W-1:0]         pkt_count;
  logic                     pkt_complete;
  logic                     pkt_free;
  logic                     tog_eff;
  logic                     start_data;

  usbfs_pkt_buf #(
    .MAX_PKT (MAX_PKT)
  ) u_pkt_buf (
    .clk        (i_clk_12MHz),
    .rst_n      (i_rst_n),
    .byte_data  (i_byte),
    .byte_valid (i_byte_valid),
    .byte_last  (i_byte_last),
    .byte_ready (o_byte_ready),
    .free       (pkt_free),
    .data       (pkt_data),
    .count      (pkt_count),
    .complete   (pkt_complete)
  );

  assign pkt_free = (state == ST_ACK_WAIT) && i_ackRcvd;
  // A clear arriving with the token already selects DATA0 for that packet.
  assign tog_eff  = toggle && !i_clrToggle;

  assign start_data = ((state == ST_IDLE) && i_inToken && !i_stall && pkt_complete) ||
                      ((state == ST_ACK_WAIT) && !i_ackRcvd && i_inToken);

  // Payload snapshot taken once per data request so it stays fixed while waiting for i_ready.
  always_ff @(posedge i_clk_12MHz) begin
    if (start_data) o_data <= pkt_data;
  end

  always_ff @(posedge i_clk_12MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      toggle        <= 1'b0;
      timer         <= '0;
      o_valid       <= 1'b0;
      o_pid         <= 4'b0000;
      o_data_nBytes <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_inToken) begin
            o_valid <= 1'b1;
            if (i_stall) begin
              state         <= ST_HS_REQ;
              o_pid         <= PID_STALL;
              o_data_nBytes <= '0;
            end else if (pkt_complete) begin
              state         <= ST_DATA_REQ;
              o_pid         <= data_pid(tog_eff);
              o_data_nBytes <= pkt_count;
            end else begin
              state         <= ST_HS_REQ;
              o_pid         <= PID_NAK;
              o_data_nBytes <= '0;
            end
          end
        end
        ST_DATA_REQ: begin
          if (i_ready) begin
            state   <= ST_DATA_TX;
            o_valid <= 1'b0;
          end
        end
        ST_HS_REQ: begin
          if (i_ready) begin
            state   <= ST_HS_TX;
            o_valid <= 1'b0;
          end
        end
        ST_DATA_TX: begin
          if (i_eopDone) begin
            state <= ST_ACK_WAIT;
            timer <= TMR_W'(ACK_TIMEOUT);
          end
        end
        ST_HS_TX: begin
          if (i_eopDone) state <= ST_IDLE;
        end
        ST_ACK_WAIT: begin
          if (i_ackRcvd) begin
            state <= ST_IDLE;
            timer <= '0;
          end else if (i_inToken) begin
            // Host missed our data and asked again: resend the same packet.
            state         <= ST_DATA_REQ;
            timer         <= '0;
            o_valid       <= 1'b1;
            o_pid         <= data_pid(tog_eff);
            o_data_nBytes <= pkt_count;
          end else if (timer <= TMR_W'(1)) begin
            state <= ST_IDLE;
            timer <= '0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
        end
      endcase

      if (i_clrToggle)   toggle <= 1'b0;
      else if (pkt_free) toggle <= ~toggle;
    end
  end

endmodule

// File: tb/tb_usbfs_in_endp.sv
// Scoreboard bench for usbfs_in_endp: expected packets are queued, a monitor checks each request.
module tb_usbfs_in_endp;
  import usbSpec::*;

  localparam int MAX_PKT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  i_byte = '0;
  logic        i_byte_valid = 1'b0;
  logic        i_byte_last = 1'b0;
  logic        o_byte_ready;
  logic        i_inToken = 1'b0;
  logic        i_ackRcvd = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_clrToggle = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic        i_eopDone = 1'b0;
  logic [3:0]  o_pid;
  logic [63:0] o_data;
  logic [3:0]  o_data_nBytes;

  typedef struct packed {
    logic [3:0]  pid;
    logic [3:0]  nb;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] mon_mask;
  int          total = 0;
  int          bad = 0;

  usbfs_in_endp #(.MAX_PKT(MAX_PKT), .ACK_TIMEOUT(24)) dut (
    .i_clk_12MHz   (clk),
    .i_rst_n       (rst_n),
    .i_byte        (i_byte),
    .i_byte_valid  (i_byte_valid),
    .i_byte_last   (i_byte_last),
    .o_byte_ready  (o_byte_ready),
    .i_inToken     (i_inToken),
    .i_ackRcvd     (i_ackRcvd),
    .i_stall       (i_stall),
    .i_clrToggle   (i_clrToggle),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .i_eopDone     (i_eopDone),
    .o_pid         (o_pid),
    .o_data        (o_data),
    .o_data_nBytes (o_data_nBytes)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted packet request is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_request: got pid %b, expected no request", o_pid);
      end else begin
        mon_e = sb.pop_front();
        mon_mask = (mon_e.nb >= 4'd8) ? '1 : ((64'd1 << (8 * mon_e.nb)) - 64'd1);
        check("pkt_pid", {60'd0, o_pid}, {60'd0, mon_e.pid});
        check("pkt_nbytes", {60'd0, o_data_nBytes}, {60'd0, mon_e.nb});
        check("pkt_data", o_data & mon_mask, mon_e.data & mon_mask);
      end
    end
  end

  task automatic expect_pkt(input logic [3:0] pid, input logic [3:0] nb, input logic [63:0] d);
    exp_t e;
    e.pid = pid;
    e.nb = nb;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic send_bytes(input logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      i_byte = d[8*i +: 8];
      i_byte_valid = 1'b1;
      i_byte_last = (i == n - 1);
      @(negedge clk);
    end
    i_byte_valid = 1'b0;
    i_byte_last = 1'b0;
  endtask

  task automatic in_token();
    i_inToken = 1'b1;
    @(negedge clk);
    i_inToken = 1'b0;
  endtask

  task automatic ack();
    i_ackRcvd = 1'b1;
    @(negedge clk);
    i_ackRcvd = 1'b0;
  endtask

  // Plays the transmitter: waits for the request, then reports EOP one cycle later.
  task automatic wait_tx(input string name);
    int n = 0;
    while (!o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!o_valid) begin
      total++;
      bad++;
      $display("FAIL %s: got no request within 20 cycles, expected o_valid", name);
    end
    @(negedge clk);
    i_eopDone = 1'b1;
    @(negedge clk);
    i_eopDone = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_pid", {60'd0, o_pid}, 64'd0);
    check("rst_nbytes", {60'd0, o_data_nBytes}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_byte_ready", {63'd0, o_byte_ready}, 64'd1);

    // Three bytes with last, then a single-byte packet on DATA1.
    send_bytes(64'hC3B2A1, 3);
    check("full_ready_low", {63'd0, o_byte_ready}, 64'd0);
    expect_pkt(PID_DATA0, 4'd3, 64'hC3B2A1);
    in_token();
    wait_tx("t1_data0");
    ack();
    check("freed_ready_high", {63'd0, o_byte_ready}, 64'd1);
    send_bytes(64'h5A, 1);
    expect_pkt(PID_DATA1, 4'd1, 64'h5A);
    in_token();
    wait_tx("t1_data1");
    ack();

    // Empty buffer answers NAK twice, proving the return to idle.
    expect_pkt(PID_NAK, 4'd0, 64'd0);
    in_token();
    check("nak_ready_high", {63'd0, o_byte_ready}, 64'd1);
    wait_tx("t2_nak");
    expect_pkt(PID_NAK, 4'd0, 64'd0);
    in_token();
    wait_tx("t2_nak2");

    // Full packet with last on byte 8 is followed by a zero-length packet.
    send_bytes(64'h0807060504030201, 8);
    expect_pkt(PID_DATA0, 4'd8, 64'h0807060504030201);
    in_token();
    wait_tx("t3_full");
    ack();
    check("zlp_ready_low", {63'd0, o_byte_ready}, 64'd0);
    expect_pkt(PID_DATA1, 4'd0, 64'd0);
    in_token();
    wait_tx("t3_zlp");
    ack();
    check("zlp_done_ready", {63'd0, o_byte_ready}, 64'd1);

    // Missing ACK: timeout, late ACK ignored, retransmit on same toggle.
    send_bytes(64'h2211, 2);
    expect_pkt(PID_DATA0, 4'd2, 64'h2211);
    in_token();
    wait_tx("t4_first");
    repeat (30) @(negedge clk);
    ack();
    check("timeout_kept", {63'd0, o_byte_ready}, 64'd0);
    expect_pkt(PID_DATA0, 4'd2, 64'h2211);
    in_token();
    wait_tx("t4_retx");
    ack();

    // Stall keeps the buffer; ACK together with clear lands on DATA0.
    send_bytes(64'h33, 1);
    i_stall = 1'b1;
    expect_pkt(PID_STALL, 4'd0, 64'd0);
    in_token();
    wait_tx("t5_stall");
    i_stall = 1'b0;
    check("stall_kept", {63'd0, o_byte_ready}, 64'd0);
    expect_pkt(PID_DATA1, 4'd1, 64'h33);
    in_token();
    wait_tx("t5_data1");
    i_clrToggle = 1'b1;
    ack();
    i_clrToggle = 1'b0;
    send_bytes(64'h44, 1);
    i_ready = 1'b0;
    expect_pkt(PID_DATA0, 4'd1, 64'h44);
    in_token();
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", {63'd0, o_valid}, 64'd1);
      check("hold_pid", {60'd0, o_pid}, {60'd0, PID_DATA0});
      @(negedge clk);
    end
    @(posedge clk);
    #1 i_ready = 1'b1;
    @(negedge clk);
    wait_tx("t5_data0");
    ack();

    // Reset while the data packet is on the wire.
    send_bytes(64'h55, 1);
    expect_pkt(PID_DATA1, 4'd1, 64'h55);
    in_token();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {63'd0, o_valid}, 64'd0);
    check("midrst_pid", {60'd0, o_pid}, 64'd0);
    check("midrst_nbytes", {60'd0, o_data_nBytes}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", {63'd0, o_byte_ready}, 64'd1);
    expect_pkt(PID_NAK, 4'd0, 64'd0);
    in_token();
    wait_tx("t6_nak");

    repeat (4) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
